// File: rtl/register_bank_sb.sv
// Register bank with 3 async read ports, writeback + link write, and a pending-write scoreboard.
// Optional same-cycle write-to-read forwarding when REGBANK_BYPASS_EN is defined.
module register_bank_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned LINK_REG = 31,
    parameter int unsigned PC_W     = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rdAddr1,
    input  logic [ADDR_W-1:0] rdAddr2,
    input  logic [ADDR_W-1:0] rdAddr3,
    output logic [DATA_W-1:0] rdData1,
    output logic [DATA_W-1:0] rdData2,
    output logic [DATA_W-1:0] rdData3,
    output logic              busy1,
    output logic              busy2,
    output logic              busy3,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              linkEn,
    input  logic [PC_W-1:0]   pc,
    input  logic              issueEn,
    input  logic [ADDR_W-1:0] issueAddr,
    output logic [ADDR_W:0]   pendCnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned NRD   = 3;
    localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pending_q;
    logic [DEPTH-1:0]  pending_d;
    logic [CNT_W-1:0]  pend_cnt_q;
    logic [CNT_W-1:0]  pend_cnt_d;

    logic [PC_W-1:0]   link_pc;
    logic [DATA_W-1:0] link_val;
    logic              wr_act;

    assign link_pc  = pc + PC_W'(1);
    assign link_val = DATA_W'(link_pc);
    assign wr_act   = wrEn && (wrAddr != '0);

    // Next-state: writeback, then link (link wins), then issue (newest producer wins).
    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        if (wr_act) begin
            regs_d[wrAddr]    = wrData;
            pending_d[wrAddr] = 1'b0;
        end
        if (linkEn) begin
            regs_d[LINK_IDX]    = link_val;
            pending_d[LINK_IDX] = 1'b0;
        end
        if (issueEn && (issueAddr != '0)) begin
            pending_d[issueAddr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        pend_cnt_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            pend_cnt_d = pend_cnt_d + CNT_W'(pending_d[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            regs_q     <= '{default: '0};
            pending_q  <= '0;
            pend_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            pending_q  <= pending_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pendCnt = pend_cnt_q;

    logic [ADDR_W-1:0] rd_addr [NRD];
    logic [DATA_W-1:0] rd_data [NRD];
    logic [NRD-1:0]    rd_busy;

    assign rd_addr[0] = rdAddr1;
    assign rd_addr[1] = rdAddr2;
    assign rd_addr[2] = rdAddr3;

    // Busy is masked when this cycle's write/link retires the pending producer.
    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic              wr_hit;
        logic              link_hit;
        logic [DATA_W-1:0] stored;

        assign wr_hit   = wr_act && (wrAddr == rd_addr[g]);
        assign link_hit = linkEn && (rd_addr[g] == LINK_IDX);
        assign stored   = (rd_addr[g] == '0) ? '0 : regs_q[rd_addr[g]];
`ifdef REGBANK_BYPASS_EN
        assign rd_data[g] = link_hit ? link_val : (wr_hit ? wrData : stored);
`else
        assign rd_data[g] = stored;
`endif
        assign rd_busy[g] = pending_q[rd_addr[g]] && !(wr_hit || link_hit);
    end

    assign rdData1 = rd_data[0];
    assign rdData2 = rd_data[1];
    assign rdData3 = rd_data[2];
    assign busy1   = rd_busy[0];
    assign busy2   = rd_busy[1];
    assign busy3   = rd_busy[2];

endmodule

// File: tb/tb_register_bank_sb.sv
// Scoreboard bench for register_bank_sb: stimulus queues expected outputs, a negedge monitor checks them.
module tb_register_bank_sb;

    logic        clock;
    logic        reset_n;
    logic [4:0]  rdAddr1, rdAddr2, rdAddr3;
    logic [31:0] rdData1, rdData2, rdData3;
    logic        busy1, busy2, busy3;
    logic        wrEn;
    logic [4:0]  wrAddr;
    logic [31:0] wrData;
    logic        linkEn;
    logic [31:0] pc;
    logic        issueEn;
    logic [4:0]  issueAddr;
    logic [5:0]  pendCnt;

    register_bank_sb dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .rdAddr1  (rdAddr1),
        .rdAddr2  (rdAddr2),
        .rdAddr3  (rdAddr3),
        .rdData1  (rdData1),
        .rdData2  (rdData2),
        .rdData3  (rdData3),
        .busy1    (busy1),
        .busy2    (busy2),
        .busy3    (busy3),
        .wrEn     (wrEn),
        .wrAddr   (wrAddr),
        .wrData   (wrData),
        .linkEn   (linkEn),
        .pc       (pc),
        .issueEn  (issueEn),
        .issueAddr(issueAddr),
        .pendCnt  (pendCnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // sig: 0..2 rdData1..3, 3..5 busy1..3, 6 pendCnt
    typedef struct {
        string       name;
        int unsigned sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string n, input int unsigned s, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.sig  = s;
        e.val  = v;
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int unsigned s);
        case (s)
            0:       return rdData1;
            1:       return rdData2;
            2:       return rdData3;
            3:       return 32'(busy1);
            4:       return 32'(busy2);
            5:       return 32'(busy3);
            default: return 32'(pendCnt);
        endcase
    endfunction

    // Forwarded value when bypass is built in, otherwise the stored value.
    function automatic logic [31:0] byp(input logic [31:0] old_v, input logic [31:0] new_v);
`ifdef REGBANK_BYPASS_EN
        return new_v;
`else
        return old_v;
`endif
    endfunction

    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clock);
            while (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = observe(e.sig);
                checks++;
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic set_idle();
        reset_n   = 1'b1;
        rdAddr1   = '0;
        rdAddr2   = '0;
        rdAddr3   = '0;
        wrEn      = 1'b0;
        wrAddr    = '0;
        wrData    = '0;
        linkEn    = 1'b0;
        pc        = '0;
        issueEn   = 1'b0;
        issueAddr = '0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
        set_idle();
    endtask

    initial begin
        set_idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        set_idle();
        push("rst_pend", 6, 0);
        push("rst_rd1", 0, 0);
        push("rst_busy1", 3, 0);

        // T1: write/issue then synchronous reset clears both
        wrEn = 1'b1; wrAddr = 5; wrData = 32'hAA; issueEn = 1'b1; issueAddr = 6;
        next_cycle();
        rdAddr1 = 5; rdAddr2 = 6;
        push("t1_rd5", 0, 32'hAA);
        push("t1_busy6", 4, 1);
        push("t1_pend", 6, 1);
        next_cycle();
        reset_n = 1'b0;
        next_cycle();
        rdAddr1 = 5; rdAddr2 = 6;
        push("t1_rd5_after_rst", 0, 0);
        push("t1_busy6_after_rst", 4, 0);
        push("t1_pend_after_rst", 6, 0);

        // T2: register 0 is never written nor pending
        next_cycle();
        wrEn = 1'b1; wrAddr = 0; wrData = 32'hFFFF_FFFF; issueEn = 1'b1; issueAddr = 0; rdAddr1 = 0;
        push("t2_rd0_same", 0, 0);
        push("t2_busy0_same", 3, 0);
        next_cycle();
        push("t2_rd0_next", 0, 0);
        push("t2_busy0_next", 3, 0);
        push("t2_pend", 6, 0);

        // T3: write r7 while reading it
        next_cycle();
        wrEn = 1'b1; wrAddr = 7; wrData = 32'h1234; rdAddr1 = 7;
        push("t3_rd7_same", 0, byp(32'h0, 32'h1234));
        next_cycle();
        rdAddr1 = 7;
        push("t3_rd7_next", 0, 32'h1234);

        // T4: link register, link beats writeback, clears pending
        next_cycle();
        issueEn = 1'b1; issueAddr = 31;
        next_cycle();
        rdAddr1 = 31;
        push("t4_busy31", 3, 1);
        push("t4_pend1", 6, 1);
        next_cycle();
        rdAddr1 = 31; pc = 32'h40; linkEn = 1'b1; wrEn = 1'b1; wrAddr = 31; wrData = 32'h99;
        push("t4_busy31_masked", 3, 0);
        push("t4_rd31_same", 0, byp(32'h0, 32'h41));
        push("t4_pend_still1", 6, 1);
        next_cycle();
        rdAddr1 = 31; wrEn = 1'b1; wrAddr = 31; wrData = 32'h77;
        push("t4_rd31_link", 0, byp(32'h41, 32'h77));
        push("t4_pend0", 6, 0);
        push("t4_busy31_clr", 3, 0);
        next_cycle();
        rdAddr1 = 31; linkEn = 1'b1; pc = 32'h40;
        push("t4_rd31_wr", 0, byp(32'h77, 32'h41));
        next_cycle();
        rdAddr1 = 31; linkEn = 1'b1; pc = 32'hFFFF_FFFF;
        push("t4_rd31_linkonly", 0, byp(32'h41, 32'h0));
        next_cycle();
        rdAddr1 = 31;
        push("t4_rd31_wrap", 0, 32'h0);

        // T5: scoreboard counting and issue-beats-write
        next_cycle();
        issueEn = 1'b1; issueAddr = 3; rdAddr1 = 3;
        push("t5_busy3_issue_cycle", 3, 0);
        next_cycle();
        issueEn = 1'b1; issueAddr = 4; rdAddr1 = 3;
        push("t5_busy3", 3, 1);
        push("t5_pend1", 6, 1);
        next_cycle();
        rdAddr1 = 3; rdAddr2 = 4;
        push("t5_busy3_b", 3, 1);
        push("t5_busy4", 4, 1);
        push("t5_pend2", 6, 2);
        next_cycle();
        wrEn = 1'b1; wrAddr = 3; wrData = 32'h33; issueEn = 1'b1; issueAddr = 3; rdAddr1 = 3;
        push("t5_busy3_wr_masked", 3, 0);
        push("t5_pend2_b", 6, 2);
        next_cycle();
        rdAddr1 = 3; rdAddr2 = 4; wrEn = 1'b1; wrAddr = 4; wrData = 32'h44;
        push("t5_pend2_reissue", 6, 2);
        push("t5_busy3_reissue", 3, 1);
        push("t5_rd3", 0, 32'h33);
        push("t5_busy4_masked", 4, 0);
        next_cycle();
        rdAddr1 = 3; rdAddr2 = 3; rdAddr3 = 3;
        push("t5_pend1_after_wr4", 6, 1);
        push("t5_alias_rd1", 0, 32'h33);
        push("t5_alias_rd2", 1, 32'h33);
        push("t5_alias_rd3", 2, 32'h33);
        push("t5_alias_busy1", 3, 1);
        push("t5_alias_busy2", 4, 1);
        push("t5_alias_busy3", 5, 1);

        // T6: reset overrides same-cycle write and issue
        next_cycle();
        reset_n = 1'b0; issueEn = 1'b1; issueAddr = 9; wrEn = 1'b1; wrAddr = 9; wrData = 32'h5;
        next_cycle();
        rdAddr1 = 9; rdAddr2 = 3; rdAddr3 = 4;
        push("t6_rd9", 0, 0);
        push("t6_busy9", 3, 0);
        push("t6_pend", 6, 0);
        push("t6_rd3", 1, 0);
        push("t6_busy3", 4, 0);
        push("t6_rd4", 2, 0);

        next_cycle();
        @(negedge clock);
        #1;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
